// File: rtl/rgb2fbuf.sv
`timescale 1ns/1ps
// rgb2fbuf: samples a parallel RGB stream, checks it against the configured active
// resolution and, once locked, writes (optionally downscaled) pixels row-major into the framebuffer.
module rgb2fbuf #(
   parameter int FRAME_WIDTH     = 640,
   parameter int FRAME_HEIGHT    = 480,
   parameter int SCALING_FACTOR  = 1,
   parameter int FBUF_ADDR_WIDTH = 19,
   parameter int PIXEL_WIDTH     = 24,
   parameter int LOCK_FRAMES     = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       vde,
   input  logic                       hsync,
   input  logic                       vsync,
   input  logic [PIXEL_WIDTH-1:0]     pixel_data,
   output logic                       fbuf_we,
   output logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr,
   output logic [PIXEL_WIDTH-1:0]     fbuf_data,
   output logic                       sof,
   output logic                       locked,
   output logic                       err,
   output logic [12:0]                measured_width,
   output logic [12:0]                measured_height
);

   localparam int          SHIFT      = (SCALING_FACTOR == 4) ? 2 : (SCALING_FACTOR == 2) ? 1 : 0;
   localparam int          LINE_WORDS = FRAME_WIDTH / SCALING_FACTOR;
   localparam logic [12:0] W13        = 13'(FRAME_WIDTH);
   localparam logic [12:0] H13        = 13'(FRAME_HEIGHT);
   localparam logic [12:0] MASK13     = 13'(SCALING_FACTOR - 1);
   localparam logic [12:0] CNT_MAX    = 13'h1FFF;
   localparam logic [3:0]  LOCK4      = 4'(LOCK_FRAMES);

   typedef enum logic [1:0] {
      ST_SEARCH  = 2'd0,
      ST_MEASURE = 2'd1,
      ST_LOCKED  = 2'd2
   } state_t;

   // Stage 1: input registers and one-cycle-delayed copies for edge detection
   logic                   r_vde;
   logic                   r_vsync;
   logic                   r_hsync_unused;
   logic [PIXEL_WIDTH-1:0] r_pix;
   logic                   r_vde_d;
   logic                   r_vsync_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_vde          <= 1'b0;
         r_vsync        <= 1'b0;
         r_hsync_unused <= 1'b0;
         r_pix          <= '0;
         r_vde_d        <= 1'b0;
         r_vsync_d      <= 1'b0;
      end else begin
         r_vde          <= vde;
         r_vsync        <= vsync;
         r_hsync_unused <= hsync;
         r_pix          <= pixel_data;
         r_vde_d        <= r_vde;
         r_vsync_d      <= r_vsync;
      end
   end

   // Stage 2: line/frame measurement
   logic [12:0] r_x_cnt;
   logic [12:0] r_y_cnt;
   logic [12:0] r_last_w;
   logic        r_frame_bad;

   logic        w_vde_fall;
   logic        w_vs_rise;
   logic        w_line_bad;
   logic [12:0] w_y_eff;
   logic [12:0] w_last_w;
   logic        w_frame_good;

   assign w_vde_fall = r_vde_d & ~r_vde;
   assign w_vs_rise  = r_vsync & ~r_vsync_d;
   assign w_line_bad = w_vde_fall && (r_x_cnt != W13);
   // A line ending in the same cycle as the frame end still belongs to that frame.
   assign w_y_eff    = (w_vde_fall && (r_y_cnt != CNT_MAX)) ? r_y_cnt + 13'd1 : r_y_cnt;
   assign w_last_w   = w_vde_fall ? r_x_cnt : r_last_w;
   assign w_frame_good = !r_frame_bad && !w_line_bad && (w_y_eff == H13) && !r_vde;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_x_cnt     <= '0;
         r_y_cnt     <= '0;
         r_last_w    <= '0;
         r_frame_bad <= 1'b0;
      end else if (w_vs_rise) begin
         r_x_cnt     <= '0;
         r_y_cnt     <= '0;
         r_last_w    <= w_last_w;
         r_frame_bad <= 1'b0;
      end else begin
         if (r_vde && (r_x_cnt != CNT_MAX)) begin
            r_x_cnt <= r_x_cnt + 13'd1;
         end
         if (w_vde_fall) begin
            r_x_cnt     <= '0;
            r_y_cnt     <= w_y_eff;
            r_last_w    <= r_x_cnt;
            r_frame_bad <= r_frame_bad | w_line_bad;
         end
      end
   end

   // Lock FSM, evaluated once per frame end
   state_t     r_state;
   state_t     w_state_next;
   logic [3:0] r_good_cnt;
   logic [3:0] w_good_next;
   logic       w_err_next;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_SEARCH;
         r_good_cnt <= '0;
      end else begin
         r_state    <= w_state_next;
         r_good_cnt <= w_good_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_good_next  = r_good_cnt;
      w_err_next   = 1'b0;
      if (w_vs_rise) begin
         case (r_state)
            ST_SEARCH: begin
               w_state_next = ST_MEASURE;
               w_good_next  = '0;
            end
            ST_MEASURE: begin
               if (w_frame_good) begin
                  w_good_next = r_good_cnt + 4'd1;
                  if (r_good_cnt + 4'd1 == LOCK4) begin
                     w_state_next = ST_LOCKED;
                  end
               end else begin
                  w_good_next = '0;
                  w_err_next  = 1'b1;
               end
            end
            ST_LOCKED: begin
               if (!w_frame_good) begin
                  w_state_next = ST_MEASURE;
                  w_good_next  = '0;
                  w_err_next   = 1'b1;
               end
            end
            default: begin
               w_state_next = ST_SEARCH;
               w_good_next  = '0;
            end
         endcase
      end
   end

   // Write generation: only in-range pixels on the downscale grid are stored
   logic                       w_wr;
   logic [31:0]                w_row;
   logic [31:0]                w_col;
   logic [FBUF_ADDR_WIDTH-1:0] w_addr;

   assign w_wr = (r_state == ST_LOCKED) && r_vde
              && (r_x_cnt < W13) && (r_y_cnt < H13)
              && ((r_x_cnt & MASK13) == 13'd0) && ((r_y_cnt & MASK13) == 13'd0);
   assign w_row  = 32'(r_y_cnt >> SHIFT) * 32'(LINE_WORDS);
   assign w_col  = 32'(r_x_cnt >> SHIFT);
   assign w_addr = FBUF_ADDR_WIDTH'(w_row + w_col);

   logic                       r_we;
   logic [FBUF_ADDR_WIDTH-1:0] r_addr;
   logic [PIXEL_WIDTH-1:0]     r_data;
   logic                       r_sof;
   logic                       r_err;
   logic [12:0]                r_meas_w;
   logic [12:0]                r_meas_h;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_data   <= '0;
         r_sof    <= 1'b0;
         r_err    <= 1'b0;
         r_meas_w <= '0;
         r_meas_h <= '0;
      end else begin
         r_we  <= w_wr;
         r_sof <= w_wr && (r_x_cnt == 13'd0) && (r_y_cnt == 13'd0);
         r_err <= w_err_next;
         if (w_wr) begin
            r_addr <= w_addr;
            r_data <= r_pix;
         end
         if (w_vs_rise) begin
            r_meas_w <= w_last_w;
            r_meas_h <= w_y_eff;
         end
      end
   end

   assign fbuf_we         = r_we;
   assign fbuf_addr       = r_addr;
   assign fbuf_data       = r_data;
   assign sof             = r_sof;
   assign err             = r_err;
   assign locked          = (r_state == ST_LOCKED);
   assign measured_width  = r_meas_w;
   assign measured_height = r_meas_h;

endmodule

// File: tb/tb_rgb2fbuf.sv
`timescale 1ns/1ps
// tb_rgb2fbuf: drives an 8x4 stream into an S=1 and an S=2 instance; directed frame table
// followed by random frames, all checked against a frame-level lock/write model.
module tb_rgb2fbuf;

   localparam int W = 8;
   localparam int H = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        vde;
   logic        hsync;
   logic        vsync;
   logic [23:0] pix;

   logic        we1, sof1, locked1, err1;
   logic [18:0] addr1;
   logic [23:0] data1;
   logic [12:0] mw1, mh1;
   logic        we2, sof2, locked2, err2;
   logic [18:0] addr2;
   logic [23:0] data2;
   logic [12:0] mw2, mh2;

   always #5 clk = ~clk;

   rgb2fbuf #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .SCALING_FACTOR(1),
              .FBUF_ADDR_WIDTH(19), .PIXEL_WIDTH(24), .LOCK_FRAMES(2)) u_s1 (
      .clk(clk), .rst_n(rst_n), .vde(vde), .hsync(hsync), .vsync(vsync), .pixel_data(pix),
      .fbuf_we(we1), .fbuf_addr(addr1), .fbuf_data(data1), .sof(sof1), .locked(locked1),
      .err(err1), .measured_width(mw1), .measured_height(mh1));

   rgb2fbuf #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .SCALING_FACTOR(2),
              .FBUF_ADDR_WIDTH(19), .PIXEL_WIDTH(24), .LOCK_FRAMES(2)) u_s2 (
      .clk(clk), .rst_n(rst_n), .vde(vde), .hsync(hsync), .vsync(vsync), .pixel_data(pix),
      .fbuf_we(we2), .fbuf_addr(addr2), .fbuf_data(data2), .sof(sof2), .locked(locked2),
      .err(err2), .measured_width(mw2), .measured_height(mh2));

   typedef struct {
      logic [18:0] addr;
      logic [23:0] data;
      logic        sof;
   } wr_t;

   typedef struct {
      int nl; int long_line; int merge; int rst_line;
      int e_err; int e_lock; int e_mw; int e_mh; int e_wr1; int e_wr2;
   } vec_t;

   int  total = 0;
   int  bad   = 0;
   wr_t q1[$];
   wr_t q2[$];
   int  wr_cnt1 = 0, wr_cnt2 = 0;
   int  err_seen1 = 0, err_seen2 = 0, err_total = 0;
   int  lw[16];
   int  m_state = 0;   // 0 searching, 1 measuring, 2 locked
   int  m_good  = 0;
   int  e_err, e_lock, e_mw, e_mh;
   int  w1, w2, nl, mg;
   vec_t vt[17];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s act=%0d exp=%0d", name, act, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " we1"}, int'(we1), 0);       chk({tag, " we2"}, int'(we2), 0);
      chk({tag, " sof1"}, int'(sof1), 0);     chk({tag, " sof2"}, int'(sof2), 0);
      chk({tag, " locked1"}, int'(locked1), 0); chk({tag, " locked2"}, int'(locked2), 0);
      chk({tag, " err1"}, int'(err1), 0);     chk({tag, " err2"}, int'(err2), 0);
      chk({tag, " mw1"}, int'(mw1), 0);       chk({tag, " mh1"}, int'(mh1), 0);
      chk({tag, " mw2"}, int'(mw2), 0);       chk({tag, " mh2"}, int'(mh2), 0);
      chk({tag, " addr1"}, int'(addr1), 0);   chk({tag, " data1"}, int'(data1), 0);
      chk({tag, " addr2"}, int'(addr2), 0);   chk({tag, " data2"}, int'(data2), 0);
   endtask

   // Expected framebuffer writes for a pixel at (x,y) when the model is locked.
   task automatic push_pixel(input int x, input int y, input logic [23:0] d);
      wr_t e;
      if (m_state == 2 && x < W && y < H) begin
         e.addr = 19'(y * W + x);
         e.data = d;
         e.sof  = (x == 0 && y == 0);
         q1.push_back(e);
         if (x % 2 == 0 && y % 2 == 0) begin
            e.addr = 19'((y / 2) * (W / 2) + x / 2);
            q2.push_back(e);
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      chk_zero("midreset");
      rst_n = 1'b1;
      m_state = 0;
      m_good  = 0;
   endtask

   // Sends nl lines (widths from lw), then a vsync rise; returns 2 cycles after the rise.
   task automatic run_frame(input int n_lines, input int merge, input int rst_line);
      int counted;
      int good;
      counted = 0;
      for (int y = 0; y < n_lines; y++) begin
         for (int x = 0; x < lw[y]; x++) begin
            vde = 1'b1;
            pix = 24'($urandom);
            push_pixel(x, y, pix);
            tick();
         end
         vde = 1'b0;
         counted++;
         if (!(merge != 0 && y == n_lines - 1)) begin
            tick(); hsync = 1'b1; tick(); hsync = 1'b0; tick();
         end
         if (y == rst_line) begin
            do_reset();
            counted = 0;
         end
      end
      good = (n_lines == H) ? 1 : 0;
      for (int y = 0; y < n_lines; y++) if (lw[y] != W) good = 0;
      vsync = 1'b1;
      tick();
      tick();
      e_err = 0;
      if (m_state == 0) begin
         m_state = 1;
         m_good  = 0;
      end else if (good == 1) begin
         if (m_state == 1) begin
            m_good++;
            if (m_good == 2) m_state = 2;
         end
      end else begin
         e_err   = 1;
         m_good  = 0;
         m_state = 1;
      end
      e_lock = (m_state == 2) ? 1 : 0;
      e_mw   = lw[n_lines - 1];
      e_mh   = counted;
      err_total += e_err;
   endtask

   task automatic end_frame();
      tick();
      vsync = 1'b0;
      tick(); tick(); tick();
   endtask

   task automatic chk_frame(input string tag, input int x_err, input int x_lock,
                            input int x_mw, input int x_mh);
      chk({tag, " err_s1"}, int'(err1), x_err);       chk({tag, " err_s2"}, int'(err2), x_err);
      chk({tag, " locked_s1"}, int'(locked1), x_lock); chk({tag, " locked_s2"}, int'(locked2), x_lock);
      chk({tag, " mw_s1"}, int'(mw1), x_mw);          chk({tag, " mw_s2"}, int'(mw2), x_mw);
      chk({tag, " mh_s1"}, int'(mh1), x_mh);          chk({tag, " mh_s2"}, int'(mh2), x_mh);
      chk({tag, " pending_s1"}, q1.size(), 0);        chk({tag, " pending_s2"}, q2.size(), 0);
   endtask

   always @(negedge clk) begin
      wr_t e;
      if (err1) err_seen1++;
      if (err2) err_seen2++;
      if (we1) begin
         wr_cnt1++;
         total++;
         if (q1.size() == 0) begin
            bad++;
            $display("FAIL wr_s1 unexpected write addr=%0d data=%h", addr1, data1);
         end else begin
            e = q1.pop_front();
            if (addr1 !== e.addr || data1 !== e.data || sof1 !== e.sof) begin
               bad++;
               $display("FAIL wr_s1 act addr=%0d data=%h sof=%0d exp addr=%0d data=%h sof=%0d",
                        addr1, data1, sof1, e.addr, e.data, e.sof);
            end
         end
      end
      if (we2) begin
         wr_cnt2++;
         total++;
         if (q2.size() == 0) begin
            bad++;
            $display("FAIL wr_s2 unexpected write addr=%0d data=%h", addr2, data2);
         end else begin
            e = q2.pop_front();
            if (addr2 !== e.addr || data2 !== e.data || sof2 !== e.sof) begin
               bad++;
               $display("FAIL wr_s2 act addr=%0d data=%h sof=%0d exp addr=%0d data=%h sof=%0d",
                        addr2, data2, sof2, e.addr, e.data, e.sof);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      //           nl lng mrg rst err lck mw mh wr1 wr2
      vt[0]  = '{4, -1, 0, -1, 0, 0, 8, 4,  0, 0};
      vt[1]  = '{4, -1, 0, -1, 0, 0, 8, 4,  0, 0};
      vt[2]  = '{4, -1, 0, -1, 0, 1, 8, 4,  0, 0};
      vt[3]  = '{4, -1, 0, -1, 0, 1, 8, 4, 32, 8};
      vt[4]  = '{4,  1, 0, -1, 1, 0, 8, 4, 32, 8};
      vt[5]  = '{4, -1, 0, -1, 0, 0, 8, 4,  0, 0};
      vt[6]  = '{4, -1, 0, -1, 0, 1, 8, 4,  0, 0};
      vt[7]  = '{4, -1, 1, -1, 0, 1, 8, 4, 32, 8};
      vt[8]  = '{5, -1, 0, -1, 1, 0, 8, 5, 32, 8};
      vt[9]  = '{4, -1, 0, -1, 0, 0, 8, 4,  0, 0};
      vt[10] = '{5, -1, 0, -1, 1, 0, 8, 5,  0, 0};
      vt[11] = '{4, -1, 0, -1, 0, 0, 8, 4,  0, 0};
      vt[12] = '{4, -1, 0, -1, 0, 1, 8, 4,  0, 0};
      vt[13] = '{4, -1, 0,  1, 0, 0, 8, 2, 16, 4};
      vt[14] = '{4, -1, 0, -1, 0, 0, 8, 4,  0, 0};
      vt[15] = '{4, -1, 0, -1, 0, 1, 8, 4,  0, 0};
      vt[16] = '{4, -1, 0, -1, 0, 1, 8, 4, 32, 8};

      rst_n = 1'b0; vde = 1'b0; hsync = 1'b0; vsync = 1'b0; pix = '0;
      tick(); tick();
      chk_zero("reset");
      rst_n = 1'b1;
      tick(); tick();

      for (int i = 0; i < 17; i++) begin
         for (int y = 0; y < 16; y++) lw[y] = W;
         if (vt[i].long_line >= 0) lw[vt[i].long_line] = W + 1;
         w1 = wr_cnt1;
         w2 = wr_cnt2;
         run_frame(vt[i].nl, vt[i].merge, vt[i].rst_line);
         chk_frame($sformatf("vec%0d", i), vt[i].e_err, vt[i].e_lock, vt[i].e_mw, vt[i].e_mh);
         chk($sformatf("vec%0d wrcnt_s1", i), wr_cnt1 - w1, vt[i].e_wr1);
         chk($sformatf("vec%0d wrcnt_s2", i), wr_cnt2 - w2, vt[i].e_wr2);
         $display("vec%0d: err=%0d locked=%0d mw=%0d mh=%0d writes=%0d/%0d",
                  i, err1, locked1, mw1, mh1, wr_cnt1 - w1, wr_cnt2 - w2);
         end_frame();
      end

      for (int i = 0; i < 24; i++) begin
         nl = ($urandom_range(0, 9) == 0) ? int'($urandom_range(3, 5)) : H;
         mg = int'($urandom_range(0, 1));
         for (int y = 0; y < 16; y++)
            lw[y] = ($urandom_range(0, 11) == 0) ? int'($urandom_range(6, 10)) : W;
         run_frame(nl, mg, -1);
         chk_frame($sformatf("rnd%0d", i), e_err, e_lock, e_mw, e_mh);
         $display("rnd%0d: lines=%0d merge=%0d err=%0d locked=%0d mw=%0d mh=%0d",
                  i, nl, mg, err1, locked1, mw1, mh1);
         end_frame();
      end

      chk("err_total_s1", err_seen1, err_total);
      chk("err_total_s2", err_seen2, err_total);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
